// File: rtl/boot_sequencer_if.sv
// Load-stream handshake plus memory write port of the boot sequencer.
// The sequencer takes the slave side; the stream source / memories take master.
interface boot_sequencer_if #(
  parameter int NUM_MEM = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);
  logic               s_valid;
  logic               s_ready;
  logic [DATA_W-1:0]  s_data;
  logic [NUM_MEM-1:0] wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;

  modport master (
    output s_valid, s_data,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer: loads header/data records into target memories, holds the
// CPU in reset, then runs it until halt or the run-cycle limit.
module boot_sequencer #(
  parameter int NUM_MEM     = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 1,
  parameter int RUN_LIMIT   = 15
) (
  input  logic               clk,
  input  logic               rst,
  boot_sequencer_if.slave    bus,
  output logic               cpu_rst,
  input  logic               halt,
  input  logic               restart,
  output logic               running,
  output logic               done,
  output logic               timeout,
  output logic               error,
  output logic [31:0]        cycle_cnt
);

  typedef enum logic [2:0] {
    LOAD_HDR,
    LOAD_DATA,
    HOLD,
    RUN,
    DONE,
    ERROR
  } state_t;

  state_t             state, state_n;
  logic [3:0]         target, target_n;
  logic [ADDR_W-1:0]  addr, addr_n;
  logic [ADDR_W:0]    remain, remain_n;
  logic [31:0]        hold_cnt, hold_n;
  logic [NUM_MEM-1:0] wr_en_n;
  logic [ADDR_W-1:0]  wr_addr_n;
  logic [DATA_W-1:0]  wr_data_n;
  logic [31:0]        cnt_n;
  logic               done_n, timeout_n, error_n;
  logic               s_ready_n, cpu_rst_n, running_n;
  logic               xfer;
  logic [3:0]         hdr_id;
  logic [ADDR_W:0]    hdr_cnt;

  assign xfer    = bus.s_valid && bus.s_ready;
  assign hdr_id  = bus.s_data[DATA_W-1 -: 4];
  assign hdr_cnt = bus.s_data[ADDR_W:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD_HDR;
      target      <= '0;
      addr        <= '0;
      remain      <= '0;
      hold_cnt    <= '0;
      bus.s_ready <= 1'b0;
      bus.wr_en   <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      cpu_rst     <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      error       <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      state       <= state_n;
      target      <= target_n;
      addr        <= addr_n;
      remain      <= remain_n;
      hold_cnt    <= hold_n;
      bus.s_ready <= s_ready_n;
      bus.wr_en   <= wr_en_n;
      bus.wr_addr <= wr_addr_n;
      bus.wr_data <= wr_data_n;
      cpu_rst     <= cpu_rst_n;
      running     <= running_n;
      done        <= done_n;
      timeout     <= timeout_n;
      error       <= error_n;
      cycle_cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    target_n  = target;
    addr_n    = addr;
    remain_n  = remain;
    hold_n    = hold_cnt;
    wr_en_n   = '0;
    wr_addr_n = bus.wr_addr;
    wr_data_n = bus.wr_data;
    cnt_n     = cycle_cnt;
    done_n    = done;
    timeout_n = timeout;
    error_n   = error;

    case (state)
      LOAD_HDR: begin
        if (xfer) begin
          if (hdr_id == 4'hF) begin
            state_n = HOLD;
            hold_n  = '0;
          end else if ({28'b0, hdr_id} >= 32'(NUM_MEM)) begin
            state_n = ERROR;
            error_n = 1'b1;
          end else if (hdr_cnt != '0) begin
            target_n = hdr_id;
            addr_n   = '0;
            remain_n = hdr_cnt;
            state_n  = LOAD_DATA;
          end
        end
      end
      LOAD_DATA: begin
        if (xfer) begin
          for (int unsigned i = 0; i < NUM_MEM; i++)
            wr_en_n[i] = (target == 4'(i));
          wr_addr_n = addr;
          wr_data_n = bus.s_data;
          addr_n    = addr + 1'b1;
          remain_n  = remain - 1'b1;
          if (remain == (ADDR_W+1)'(1))
            state_n = LOAD_HDR;
        end
      end
      HOLD: begin
        hold_n = hold_cnt + 1'b1;
        if (hold_cnt == 32'(HOLD_CYCLES - 1)) begin
          state_n = RUN;
          cnt_n   = cycle_cnt + 1'b1;
        end
      end
      RUN: begin
        // halt is tested first so it wins over a simultaneous limit hit
        if (halt) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else if (RUN_LIMIT != 0 && cycle_cnt == 32'(RUN_LIMIT)) begin
          state_n   = DONE;
          done_n    = 1'b1;
          timeout_n = 1'b1;
        end else if (cycle_cnt != '1) begin
          cnt_n = cycle_cnt + 1'b1;
        end
      end
      DONE, ERROR: begin
        if (restart) begin
          state_n   = LOAD_HDR;
          done_n    = 1'b0;
          timeout_n = 1'b0;
          error_n   = 1'b0;
          cnt_n     = '0;
        end
      end
      default: state_n = LOAD_HDR;
    endcase

    // Status outputs are registered from the next state so they reset cleanly
    s_ready_n = (state_n == LOAD_HDR) || (state_n == LOAD_DATA);
    cpu_rst_n = (state_n != RUN);
    running_n = (state_n == RUN);
  end

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 SHALL have parameter NUM_MEM, default 3, the number of target memories (0=instruction, 1=data, 2=register file).
REQ-002 SHALL have parameter ADDR_W, default 8, the target write-address width.
REQ-003 SHALL have parameter DATA_W, default 32, the stream and write-data width; legal range is ADDR_W+5 or more.
REQ-004 SHALL have parameter HOLD_CYCLES, default 1, the CPU reset cycles held after load (at least 1).
REQ-005 SHALL have parameter RUN_LIMIT, default 15, the maximum CPU run cycles; 0 means unlimited.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port s_valid, input, 1 bit: load-stream word valid.
REQ-009 SHALL have port s_ready, output, 1 bit: load-stream word accepted.
REQ-010 SHALL have port s_data, input, DATA_W bits: load-stream word.
REQ-011 SHALL have port wr_en, output, NUM_MEM bits: one-hot write strobe per target memory.
REQ-012 SHALL have port wr_addr, output, ADDR_W bits: write address.
REQ-013 SHALL have port wr_data, output, DATA_W bits: write data.
REQ-014 SHALL have port cpu_rst, output, 1 bit: active-high reset to the CPU top.
REQ-015 SHALL have port halt, input, 1 bit: CPU end-of-program indication.
REQ-016 SHALL have port restart, input, 1 bit: returns the block from DONE or ERROR to loading.
REQ-017 SHALL have port running, output, 1 bit: high while the CPU executes.
REQ-018 SHALL have port done, output, 1 bit: high once the run has finished.
REQ-019 SHALL have port timeout, output, 1 bit: high when the run ended by RUN_LIMIT.
REQ-020 SHALL have port error, output, 1 bit: high after a bad header.
REQ-021 SHALL have port cycle_cnt, output, 32 bits: CPU run cycles executed.

Function
REQ-022 SHALL implement states LOAD_HDR, LOAD_DATA, HOLD, RUN, DONE and ERROR.
REQ-023 SHALL drive s_ready=1 only in LOAD_HDR and LOAD_DATA; a word transfers when s_valid and s_ready are both 1 on a clock edge.
REQ-024 SHALL decode a header word as target id = s_data[DATA_W-1:DATA_W-4] and count = s_data[ADDR_W:0].
REQ-025 SHALL, in LOAD_HDR, treat target id 4'hF as end-of-load and go to HOLD; count is ignored.
REQ-026 SHALL, in LOAD_HDR, go to ERROR on a target id of NUM_MEM or above (other than 4'hF), and drive error=1.
REQ-027 SHALL, in LOAD_HDR, stay in LOAD_HDR on a valid target with count=0, with no writes.
REQ-028 SHALL, in LOAD_HDR, latch the target on a valid target with count>0, clear the address to 0, set remaining=count, and go to LOAD_DATA.
REQ-029 SHALL, for each LOAD_DATA transfer, pulse wr_en[target] for exactly one cycle, on the cycle after the transfer, with wr_addr=current address and wr_data=the word.
REQ-030 SHALL, after each LOAD_DATA transfer, increment the address and decrement remaining; when remaining was 1 it SHALL return to LOAD_HDR.
REQ-031 SHALL wrap the address from 2^ADDR_W-1 to 0 with no error when count equals 2^ADDR_W.
REQ-032 SHALL keep wr_en all-zero in every cycle that has no pending write, including during back-to-back transfers.
REQ-033 SHALL hold cpu_rst=1 in LOAD_HDR, LOAD_DATA, HOLD, DONE and ERROR.
REQ-034 SHALL stay in HOLD for exactly HOLD_CYCLES cycles after the end-of-load transfer, then enter RUN.
REQ-035 SHALL, in RUN, drive cpu_rst=0 and running=1, and increment cycle_cnt by 1 each cycle, starting at 1 in the first RUN cycle.
REQ-036 SHALL go from RUN to DONE on halt=1 in RUN, with done=1 and timeout=0.
REQ-037 SHALL go from RUN to DONE with done=1 and timeout=1 when RUN_LIMIT>0 and cycle_cnt equals RUN_LIMIT.
REQ-038 SHALL give halt priority when halt=1 and the RUN_LIMIT condition occur in the same cycle, so timeout=0.
REQ-039 SHALL freeze cycle_cnt in DONE and ERROR.
REQ-040 SHALL ignore halt outside RUN.
REQ-041 SHALL, on restart=1 in DONE or ERROR, go to LOAD_HDR next cycle and clear done, timeout, error and cycle_cnt.
REQ-042 SHALL ignore restart in all other states.
REQ-043 SHALL let cycle_cnt saturate at 2^32-1 when RUN_LIMIT=0.

Reset
REQ-044 SHALL, while rst=0, asynchronously force state=LOAD_HDR, cpu_rst=1, s_ready=0, wr_en=0, wr_addr=0, wr_data=0, running=0, done=0, timeout=0, error=0 and cycle_cnt=0.
REQ-045 SHALL discard any partially loaded record on reset assertion mid-load or mid-run; the next load starts with a header.
REQ-046 SHALL raise s_ready on the first clock edge after rst deasserts.

Verification
REQ-047 SHALL pass the test: stream 0x00000002, 0xAAAA0001, 0xBBBB0002, 0xF0000000 -> wr_en=3'b001 at addresses 0 and 1 with those data, then 1 HOLD cycle, then cpu_rst falls.
REQ-048 SHALL pass the test: load a program with no halt -> cycle_cnt reaches 15, done=1, timeout=1, cpu_rst=1.
REQ-049 SHALL pass the test: halt=1 at RUN cycle 7 -> done=1, timeout=0, cycle_cnt=7; halt at cycle 15 -> timeout=0.
REQ-050 SHALL pass the test: header target id 3 with NUM_MEM=3 -> error=1, s_ready=0; restart -> LOAD_HDR with error=0.
REQ-051 SHALL pass the test: rst=0 mid-LOAD_DATA after 1 of 4 words -> all outputs at reset values; reload completes normally.
REQ-052 SHALL pass the test: random s_valid gaps plus count=256 with ADDR_W=8 -> 256 single-cycle writes, addresses 0..255, none lost or duplicated.
